// File: rtl/sicaklik_monitor.sv
// rtl/sicaklik_monitor.sv - temperature smoothing, min/max tracking and over-temperature alarm
//
// Consumes one signed 8-bit degC word per sicaklik_valid strobe, keeps a
// power-of-two moving average, tracks raw min/max and drives a hysteresis
// alarm with persistence filtering.
//
// Ports:
//   clk             in   system clock
//   reset_count     in   asynchronous active-high reset
//   sicaklik_i      in   [7:0] signed temperature sample
//   sicaklik_valid  in   one-cycle strobe qualifying sicaklik_i
//   clear_minmax    in   one-cycle strobe restarting min/max tracking
//   avg_o           out  [7:0] signed moving average
//   avg_valid       out  one-cycle pulse when avg_o is updated
//   min_o           out  [7:0] smallest raw sample since reset/clear
//   max_o           out  [7:0] largest raw sample since reset/clear
//   alarm_o         out  over-temperature level
//   alarm_rise      out  one-cycle pulse on alarm_o rising

module sicaklik_monitor #(
  parameter int                AVG_LOG2 = 3,
  parameter logic signed [7:0] HI_TH    = 8'sd70,
  parameter logic signed [7:0] LO_TH    = 8'sd65,
  parameter int                PERSIST  = 3
) (
  input  logic       clk,
  input  logic       reset_count,
  input  logic [7:0] sicaklik_i,
  input  logic       sicaklik_valid,
  input  logic       clear_minmax,
  output logic [7:0] avg_o,
  output logic       avg_valid,
  output logic [7:0] min_o,
  output logic [7:0] max_o,
  output logic       alarm_o,
  output logic       alarm_rise
);

  localparam int                 N       = 1 << AVG_LOG2;
  localparam int                 SW      = 8 + AVG_LOG2;
  localparam logic [AVG_LOG2:0]  FILL_N  = (AVG_LOG2 + 1)'(N);
  localparam logic [3:0]         PERSIST_C = 4'(PERSIST);

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_ALARM  = 1'b1;

  // ---------------------------------------------------------------------------
  // Moving average
  // ---------------------------------------------------------------------------
  logic [7:0]           sample_mem [N];
  logic [AVG_LOG2-1:0]  wptr;
  logic [AVG_LOG2:0]    fill;
  logic signed [SW-1:0] sum;
  logic                 avg_pend;

  logic signed [SW-1:0] sample_ext;
  logic signed [SW-1:0] old_ext;
  logic                 fill_after_full;

  assign sample_ext = {{AVG_LOG2{sicaklik_i[7]}}, sicaklik_i};
  assign old_ext    = {{AVG_LOG2{sample_mem[wptr][7]}}, sample_mem[wptr]};

  // True when the buffer holds N samples once this strobe is absorbed.
  assign fill_after_full = (fill == FILL_N) || (fill == FILL_N - 1'b1);

  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      for (int i = 0; i < N; i++) begin
        sample_mem[i] <= '0;
      end
      wptr     <= '0;
      fill     <= '0;
      sum      <= '0;
      avg_pend <= 1'b0;
    end else begin
      avg_pend <= sicaklik_valid && fill_after_full;
      if (sicaklik_valid) begin
        // Drop the oldest sample from the window and add the new one.
        sum              <= sum + sample_ext - old_ext;
        sample_mem[wptr] <= sicaklik_i;
        wptr             <= wptr + 1'b1;
        if (fill != FILL_N) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

  // Arithmetic right shift by AVG_LOG2 is just the upper 8 bits of the sum;
  // the mean of N 8-bit values always fits, and dropping low bits floors.
  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      avg_o     <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= avg_pend;
      if (avg_pend) begin
        avg_o <= sum[SW-1:AVG_LOG2];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Raw min / max
  // ---------------------------------------------------------------------------
  logic have_sample;

  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      min_o       <= '0;
      max_o       <= '0;
      have_sample <= 1'b0;
    end else begin
      if (sicaklik_valid) begin
        have_sample <= 1'b1;
        // A clear coinciding with a sample makes that sample the new baseline.
        if (clear_minmax || !have_sample) begin
          min_o <= sicaklik_i;
          max_o <= sicaklik_i;
        end else begin
          if ($signed(sicaklik_i) < $signed(min_o)) begin
            min_o <= sicaklik_i;
          end
          if ($signed(sicaklik_i) > $signed(max_o)) begin
            max_o <= sicaklik_i;
          end
        end
      end else if (clear_minmax) begin
        // Outputs hold their stale values until the next sample reloads them.
        have_sample <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Over-temperature alarm
  // ---------------------------------------------------------------------------
  logic [0:0]       state;
  logic [3:0]       cnt;
  logic [3:0]       cnt_inc;
  logic signed [7:0] avg_s;
  logic             hi_hit;
  logic             lo_hit;

  assign avg_s   = avg_o;
  assign hi_hit  = (avg_s >= HI_TH);
  assign lo_hit  = (avg_s <= LO_TH);
  assign cnt_inc = cnt + 4'd1;
  assign alarm_o = (state == ST_ALARM);

  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      state      <= ST_NORMAL;
      cnt        <= '0;
      alarm_rise <= 1'b0;
    end else begin
      alarm_rise <= 1'b0;
      if (avg_valid) begin
        case (state)
          ST_NORMAL: begin
            if (hi_hit) begin
              if (cnt_inc == PERSIST_C) begin
                state      <= ST_ALARM;
                cnt        <= '0;
                alarm_rise <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt <= '0;
            end
          end
          default: begin
            if (lo_hit) begin
              if (cnt_inc == PERSIST_C) begin
                state <= ST_NORMAL;
                cnt   <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sicaklik_monitor.sv
// tb/tb_sicaklik_monitor.sv - scoreboard testbench for sicaklik_monitor

module tb_sicaklik_monitor;

  logic       clk = 1'b0;
  logic       reset_count = 1'b0;
  logic [7:0] sicaklik_i = '0;
  logic       sicaklik_valid = 1'b0;
  logic       clear_minmax = 1'b0;
  logic [7:0] avg_o;
  logic       avg_valid;
  logic [7:0] min_o;
  logic [7:0] max_o;
  logic       alarm_o;
  logic       alarm_rise;

  sicaklik_monitor dut (
    .clk            (clk),
    .reset_count    (reset_count),
    .sicaklik_i     (sicaklik_i),
    .sicaklik_valid (sicaklik_valid),
    .clear_minmax   (clear_minmax),
    .avg_o          (avg_o),
    .avg_valid      (avg_valid),
    .min_o          (min_o),
    .max_o          (max_o),
    .alarm_o        (alarm_o),
    .alarm_rise     (alarm_rise)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int avg;
    int cyc;
    bit alarm;
    bit rise;
  } exp_t;

  exp_t sb[$];

  // Reference model state (stimulus side)
  int m_buf[8];
  int m_wp;
  int m_fill;
  int m_cnt;
  bit m_alarm;

  function automatic int m_sum();
    int s = 0;
    for (int i = 0; i < 8; i++) s += m_buf[i];
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_buf[i] = 0;
    m_wp = 0; m_fill = 0; m_cnt = 0; m_alarm = 0;
    sb.delete();
  endtask

  task automatic drive(input int x, input bit clr);
    int  a;
    bit  rise;
    @(posedge clk); #1;
    sicaklik_i     = 8'(x);
    sicaklik_valid = 1'b1;
    clear_minmax   = clr;
    m_buf[m_wp] = x;
    m_wp = (m_wp + 1) % 8;
    if (m_fill < 8) m_fill++;
    if (m_fill == 8) begin
      a    = m_sum() >>> 3;
      rise = 0;
      if (!m_alarm) begin
        if (a >= 70) begin
          m_cnt++;
          if (m_cnt == 3) begin m_alarm = 1; m_cnt = 0; rise = 1; end
        end else m_cnt = 0;
      end else begin
        if (a <= 65) begin
          m_cnt++;
          if (m_cnt == 3) begin m_alarm = 0; m_cnt = 0; end
        end else m_cnt = 0;
      end
      sb.push_back('{a, cyc + 2, m_alarm, rise});
    end
  endtask

  // Choose the sample that makes the next average land exactly on target.
  task automatic drive_avg(input int target);
    drive(target * 8 - (m_sum() - m_buf[m_wp]), 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      sicaklik_valid = 1'b0;
      clear_minmax   = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset_count    = 1'b1;
    sicaklik_valid = 1'b0;
    clear_minmax   = 1'b0;
    #1;
    check("rst_avg_o", int'(avg_o), 0);
    check("rst_avg_valid", int'(avg_valid), 0);
    check("rst_min_o", int'(min_o), 0);
    check("rst_max_o", int'(max_o), 0);
    check("rst_alarm_o", int'(alarm_o), 0);
    check("rst_alarm_rise", int'(alarm_rise), 0);
    model_reset();
    @(negedge clk);
    @(posedge clk); #1;
    reset_count = 1'b0;
  endtask

  // Output side: pop scoreboard on avg_valid, then check alarm one edge later.
  bit pend = 0;
  bit p_alarm;
  bit p_rise;
  exp_t e;

  always @(negedge clk) begin
    if (reset_count) begin
      pend = 0;
    end else begin
      if (pend) begin
        check("alarm_o", int'(alarm_o), int'(p_alarm));
        check("alarm_rise", int'(alarm_rise), int'(p_rise));
        pend = 0;
      end else if (alarm_rise) begin
        check("alarm_rise_spurious", int'(alarm_rise), 0);
      end
      if (avg_valid) begin
        if (sb.size() == 0) begin
          check("avg_valid_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("avg_o", int'($signed(avg_o)), e.avg);
          check("avg_latency", cyc, e.cyc);
          pend    = 1;
          p_alarm = e.alarm;
          p_rise  = e.rise;
        end
      end
    end
  end

  initial begin
    model_reset();
    do_reset();

    // Fill: first average only after the 8th sample
    for (int i = 0; i < 8; i++) drive(25, 1'b0);
    idle(4);
    check("fill_avg", int'($signed(avg_o)), 25);

    // Window slide 20 -> 28
    for (int i = 0; i < 8; i++) drive(20, 1'b0);
    for (int i = 0; i < 8; i++) drive(28, 1'b0);
    idle(4);
    check("window_avg", int'($signed(avg_o)), 28);

    // Negative floor: mean -2.5 floors to -3
    for (int i = 0; i < 8; i++) drive((i % 2) ? -2 : -3, 1'b0);
    idle(4);
    check("neg_avg_raw", int'(avg_o), 253);

    // Mid-operation reset: buffer must restart empty
    do_reset();
    for (int i = 0; i < 7; i++) drive(30, 1'b0);
    idle(4);
    check("refill_no_avg", int'(avg_o), 0);
    drive(30, 1'b0);
    idle(4);
    check("refill_avg", int'($signed(avg_o)), 30);

    // Alarm with hysteresis and persistence
    do_reset();
    for (int i = 0; i < 8; i++) drive(70, 1'b0);
    drive_avg(70);
    drive_avg(70);
    idle(3);
    check("alarm_set", int'(alarm_o), 1);
    for (int i = 0; i < 5; i++) drive_avg(66);
    idle(3);
    check("alarm_hold_band", int'(alarm_o), 1);
    drive_avg(65);
    drive_avg(65);
    drive_avg(70);
    drive_avg(65);
    drive_avg(65);
    idle(3);
    check("alarm_hold_pre", int'(alarm_o), 1);
    drive_avg(65);
    idle(3);
    check("alarm_clear", int'(alarm_o), 0);

    // Min/max tracking
    do_reset();
    drive(10, 1'b0);
    drive(-5, 1'b0);
    drive(40, 1'b0);
    idle(1);
    check("min_a", int'($signed(min_o)), -5);
    check("max_a", int'($signed(max_o)), 40);
    drive(12, 1'b1);
    idle(1);
    check("min_clr", int'($signed(min_o)), 12);
    check("max_clr", int'($signed(max_o)), 12);
    drive(3, 1'b0);
    idle(1);
    check("min_b", int'($signed(min_o)), 3);
    check("max_b", int'($signed(max_o)), 12);
    @(posedge clk); #1;
    clear_minmax = 1'b1;
    idle(1);
    check("min_hold", int'($signed(min_o)), 3);
    check("max_hold", int'($signed(max_o)), 12);
    drive(7, 1'b0);
    idle(1);
    check("min_reload", int'($signed(min_o)), 7);
    check("max_reload", int'($signed(max_o)), 7);
    drive(-50, 1'b0);
    idle(1);
    check("min_under", int'($signed(min_o)), -50);
    check("max_under", int'($signed(max_o)), 7);

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    idle(2);
    check("sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
